// File: rtl/nibble_serial_alu_ctrl.sv
// Nibble-serial add/subtract sequencer.
// A single 4-bit add slice is reused across NIB = WIDTH/4 clocks.
// Nibbles are processed least significant first, and the carry is held in a register between nibbles.
// Subtraction is done as a + ~b + ~borrow_in.
// The result, carry and signed overflow are published only on the final nibble.
//
// state | meaning
// IDLE  | waiting for start; sum/cout/ovf hold the last result
// RUN   | one nibble of the operands goes through the slice per clock
// DONE  | one-cycle completion pulse, then back to IDLE
module nibble_serial_alu_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;   // b already inverted for subtract
    logic [WIDTH-1:0]  work;

    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [3:0]        slice_s;
    logic              slice_co;
    logic [WIDTH-1:0]  result_next;
    logic              last_nib;

    // Select the current nibble of each operand and run it through the shared slice.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (idx == IDXW'(i)) begin
                nib_a = op_a[i*4 +: 4];
                nib_b = op_b[i*4 +: 4];
            end
        end
        {slice_co, slice_s} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
    end

    // Form the working result with the current slice sum merged into nibble idx.
    always_comb begin
        result_next = work;
        for (int i = 0; i < NIB; i++) begin
            if (idx == IDXW'(i)) begin
                result_next[i*4 +: 4] = slice_s;
            end
        end
    end

    assign last_nib = (idx == IDX_LAST);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A start seen in RUN or DONE is dropped, not queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, per-nibble accumulation, and the final result update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        idx   <= '0;
                        work  <= '0;
                    end
                end
                RUN: begin
                    work  <= result_next;
                    carry <= slice_co;
                    idx   <= idx + IDXW'(1);
                    if (last_nib) begin
                        sum  <= result_next;
                        cout <= slice_co;
                        ovf  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                (result_next[WIDTH-1] != op_a[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed bench for nibble_serial_alu_ctrl with WIDTH=16.
// Inputs are driven and outputs are sampled 1ns after each rising edge.
module tb_nibble_serial_alu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;

    nibble_serial_alu_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completion pulses away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation.
    // Wait (bounded) for done, then check the latency, the outputs and the return to IDLE.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tsub, input logic tcin,
                          input logic [15:0] esum, input logic ecout, input logic eovf);
        int cyc;
        a = ta; b = tb_; sub = tsub; cin = tcin; start = 1'b1;
        tick();
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; sub = ~tsub; cin = ~tcin;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        tick();
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_sum_hold"}, 32'(sum), 32'(esum));
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_no_done", 32'(done_cnt), 32'd0);

        run_op("add_ripple", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
        run_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add_cin",    16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        run_op("sub_wrap",   16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_borrow", 16'h0010, 16'h0005, 1'b1, 1'b1, 16'h000A, 1'b1, 1'b0);

        // Hold start high; the operand changes after acceptance must not matter.
        d0 = done_cnt;
        a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();                     // E0
        tick();                     // E1
        a = 16'h00FF;
        tick();                     // E2
        tick();                     // E3
        tick();                     // E4
        check("hold_done1", 32'(done), 32'd1);
        check("hold_sum1", 32'(sum), 32'h0002);
        tick();                     // E5: DONE -> IDLE, start ignored
        check("hold_idle_busy", 32'(busy), 32'd0);
        check("hold_idle_done", 32'(done), 32'd0);
        tick();                     // E6: accepted in IDLE
        check("hold_busy2", 32'(busy), 32'd1);
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();                     // E10
        check("hold_done2", 32'(done), 32'd1);
        check("hold_sum2", 32'(sum), 32'h0100);
        tick();
        tick();
        check("hold_pulses", 32'(done_cnt - d0), 32'd2);

        // Reset in the middle of RUN aborts without a done pulse.
        d0 = done_cnt;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();                     // E0
        start = 1'b0;
        tick();                     // E1
        rst_n = 1'b0;
        tick();                     // E2 reset
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        tick();
        tick();
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_rst_sum_hold", 32'(sum), 32'd0);
        run_op("after_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        check("after_rst_pulses", 32'(done_cnt - d0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nibble_serial_alu_ctrl.md
Name: nibble_serial_alu_ctrl

Overview:
- Sequencer that reuses a single 4-bit add slice (4-bit A, 4-bit B, carry-in → 4-bit sum, carry-out) to add or subtract WIDTH-bit operands, one nibble per clock, least significant nibble first.
- Holds the inter-nibble carry in a register.
- Sits between a requester using a start/done handshake and the shared nibble adder datapath.
- Outputs the full-width result, carry and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and ≥ 4. NIB = WIDTH/4 nibble steps.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- start  in  1  request; accepted only when state is IDLE
- sub  in  1  0 = add (a+b+cin); 1 = subtract (a−b−cin)
- cin  in  1  add: carry-in; subtract: borrow-in
- a  in  WIDTH  operand A, captured on accept
- b  in  WIDTH  operand B, captured on accept
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse
- sum  out  WIDTH  result register
- cout  out  1  carry out of MSB nibble; for subtract, 1 = no borrow
- ovf  out  1  two's-complement signed overflow of the full-width operation

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset, while rst_n is low at an edge:
  - state = IDLE, idx = 0, carry register = 0, operand registers = 0.
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
  - Reset mid-RUN aborts the operation and clears everything to the above; no done pulse is produced.
- States and transitions:
  - IDLE: start=1 at an edge → capture a, b, sub. Load B' = sub ? ~b : b. Load carry = sub ? ~cin : cin. Set idx = 0 and go to RUN. start=0 → stay in IDLE.
  - RUN: each edge drives nibble idx of A and B' plus the carry register into the slice.
    - Write the slice sum into working nibble idx.
    - carry ← slice carry-out; idx ← idx+1.
    - On the edge processing idx = NIB−1:
      - copy the full working result to sum;
      - cout ← slice carry-out;
      - ovf ← (A[MSB] == B'[MSB]) && (result[MSB] != A[MSB]);
      - go to DONE.
  - DONE: done = 1 for exactly this cycle; the next edge returns to IDLE.
- Latency: start sampled at edge E0 → busy high from after E0 through E_NIB. done high between E_NIB and E_NIB+1 (NIB cycles after acceptance; 4 for WIDTH=16). Throughput is one operation per NIB+2 cycles.
- start is ignored while in RUN or DONE. It is not queued; the requester must re-assert it in IDLE.
- a, b, sub and cin may change freely after acceptance; captured copies are used.
- sum, cout and ovf change only on the final RUN edge. They hold their values through DONE and IDLE until the next operation completes. Intermediate nibbles are never visible on sum.
- Arithmetic is modulo 2^WIDTH; no saturation.
  - idx counter width: clog2(NIB), minimum 1 bit.
  - Wrap-around cases: 0xFFFF+1 → sum 0x0000, cout=1. 0x0000−1 → sum 0xFFFF, cout=0.
- WIDTH=4 (NIB=1): a single RUN cycle; the same rules apply.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 edges, then release with start=0 → busy=0, done=0, sum=0x0000, cout=0, ovf=0 indefinitely.
- Basic add with ripple: a=0x1234, b=0x0FCD, sub=0, cin=0, start pulsed at E0 → busy=1 for E1..E4; done=1 only after E4; sum=0x2201, cout=0, ovf=0.
- Wrap and overflow:
  - a=0xFFFF, b=0x0001, add → sum=0x0000, cout=1, ovf=0.
  - a=0x7FFF, b=0x0001, add → sum=0x8000, cout=0, ovf=1.
- Subtract with borrow:
  - a=0x0000, b=0x0001, sub=1, cin=0 → sum=0xFFFF, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
  - a=0x0010, b=0x0005, sub=1, cin=1 → sum=0x000A, cout=1.
- start during RUN/DONE and operand change: hold start=1 continuously with a=0x0001, b=0x0001, and change a to 0x00FF at E2 → first result 0x0002. The second operation is accepted only at the IDLE edge (E6) and yields 0x0100. Exactly one done pulse per operation.
- Reset mid-operation: start at E0, rst_n=0 at E2 → all outputs 0, no done pulse. The next start after release completes normally in 4 cycles.
